// File: rtl/conv_window_sequencer.sv
// Sequencer for one 2-D valid-mode convolution using a single time-shared MAC.
// Reads image/kernel RAMs (1-cycle read latency) and writes saturated results to an output RAM.
module conv_window_sequencer #(
    parameter int SIZE      = 8,
    parameter int SIZEKer   = 3,
    parameter int WIDTH_BIT = 16,
    parameter int FRAC      = 0,
    localparam int OUT  = SIZE - SIZEKer + 1,
    localparam int IA_W = (SIZE * SIZE > 1) ? $clog2(SIZE * SIZE) : 1,
    localparam int KA_W = (SIZEKer * SIZEKer > 1) ? $clog2(SIZEKer * SIZEKer) : 1,
    localparam int OA_W = (OUT * OUT > 1) ? $clog2(OUT * OUT) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [IA_W-1:0]             img_addr,
    input  logic signed [WIDTH_BIT-1:0] img_rdata,
    output logic [KA_W-1:0]             ker_addr,
    input  logic signed [WIDTH_BIT-1:0] ker_rdata,
    output logic                        out_we,
    output logic [OA_W-1:0]             out_addr,
    output logic signed [WIDTH_BIT-1:0] out_data
);

    localparam int CNT_W = $clog2(SIZE + 1);
    localparam int ACC_W = 2 * WIDTH_BIT + $clog2(SIZEKer * SIZEKer);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - WIDTH_BIT + 1){1'b0}}, {(WIDTH_BIT - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - WIDTH_BIT + 1){1'b1}}, {(WIDTH_BIT - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAST,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          oi_q, oi_d, oj_q, oj_d;
    logic [CNT_W-1:0]          ki_q, ki_d, kj_q, kj_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d, acc_shift;
    logic signed [2*WIDTH_BIT-1:0] prod;
    logic                      tap_valid_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            oi_q        <= '0;
            oj_q        <= '0;
            ki_q        <= '0;
            kj_q        <= '0;
            acc_q       <= '0;
            tap_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            oi_q        <= oi_d;
            oj_q        <= oj_d;
            ki_q        <= ki_d;
            kj_q        <= kj_d;
            acc_q       <= acc_d;
            tap_valid_q <= (state_q == S_FETCH);
        end
    end

    assign prod = img_rdata * ker_rdata;

    always_comb begin
        state_d = state_q;
        oi_d    = oi_q;
        oj_d    = oj_q;
        ki_d    = ki_q;
        kj_d    = kj_q;
        acc_d   = acc_q;
        // RAM data trails its address by one cycle, so the MAC runs one state behind FETCH.
        if (tap_valid_q) begin
            acc_d = acc_q + ACC_W'(prod);
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    oi_d    = '0;
                    oj_d    = '0;
                    ki_d    = '0;
                    kj_d    = '0;
                    acc_d   = '0;
                end
            end
            S_FETCH: begin
                if (kj_q == CNT_W'(SIZEKer - 1)) begin
                    kj_d = '0;
                    if (ki_q == CNT_W'(SIZEKer - 1)) begin
                        ki_d    = '0;
                        state_d = S_LAST;
                    end else begin
                        ki_d = ki_q + CNT_W'(1);
                    end
                end else begin
                    kj_d = kj_q + CNT_W'(1);
                end
            end
            S_LAST: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                acc_d = '0;
                if (oj_q == CNT_W'(OUT - 1)) begin
                    oj_d = '0;
                    if (oi_q == CNT_W'(OUT - 1)) begin
                        oi_d    = '0;
                        state_d = S_DONE;
                    end else begin
                        oi_d    = oi_q + CNT_W'(1);
                        state_d = S_FETCH;
                    end
                end else begin
                    oj_d    = oj_q + CNT_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign acc_shift = acc_q >>> FRAC;

    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        out_we   = (state_q == S_WRITE);
        img_addr = '0;
        ker_addr = '0;
        out_addr = '0;
        out_data = '0;
        if (state_q == S_FETCH) begin
            img_addr = IA_W'((int'(oi_q) + int'(ki_q)) * SIZE + int'(oj_q) + int'(kj_q));
            ker_addr = KA_W'(int'(ki_q) * SIZEKer + int'(kj_q));
        end
        if (state_q == S_WRITE) begin
            out_addr = OA_W'(int'(oi_q) * OUT + int'(oj_q));
            if (acc_shift > SAT_MAX) begin
                out_data = {1'b0, {(WIDTH_BIT - 1){1'b1}}};
            end else if (acc_shift < SAT_MIN) begin
                out_data = {1'b1, {(WIDTH_BIT - 1){1'b0}}};
            end else begin
                out_data = acc_shift[WIDTH_BIT-1:0];
            end
        end
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Randomized bench for conv_window_sequencer: RAM models around the DUT and a
// direct-arithmetic convolution reference for every written result.
module tb_conv_window_sequencer;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               busy, done, out_we;
    logic [5:0]         img_addr;
    logic [3:0]         ker_addr;
    logic [5:0]         out_addr;
    logic signed [15:0] img_rdata, ker_rdata, out_data;

    logic               start3 = 1'b0;
    logic               busy3, done3, out_we3;
    logic [3:0]         img_addr3, ker_addr3;
    logic [0:0]         out_addr3;
    logic signed [15:0] img_rdata3, ker_rdata3, out_data3;

    logic signed [15:0] img_mem [0:63];
    logic signed [15:0] ker_mem [0:15];
    logic signed [15:0] img3_mem [0:15];
    logic signed [15:0] ker3_mem [0:15];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    conv_window_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .img_addr(img_addr), .img_rdata(img_rdata),
        .ker_addr(ker_addr), .ker_rdata(ker_rdata),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
    );

    conv_window_sequencer #(.SIZE(3), .SIZEKer(3), .WIDTH_BIT(16), .FRAC(1)) dut3 (
        .clock(clock), .reset(reset), .start(start3), .busy(busy3), .done(done3),
        .img_addr(img_addr3), .img_rdata(img_rdata3),
        .ker_addr(ker_addr3), .ker_rdata(ker_rdata3),
        .out_we(out_we3), .out_addr(out_addr3), .out_data(out_data3)
    );

    // Synchronous-read RAMs, one cycle of latency.
    always @(posedge clock) begin
        img_rdata  <= img_mem[img_addr];
        ker_rdata  <= ker_mem[ker_addr];
        img_rdata3 <= img3_mem[img_addr3];
        ker_rdata3 <= ker3_mem[ker_addr3];
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint model(input int oi, input int oj);
        longint s = 0;
        for (int ki = 0; ki < 3; ki++)
            for (int kj = 0; kj < 3; kj++)
                s += longint'(img_mem[(oi + ki) * 8 + oj + kj]) * longint'(ker_mem[ki * 3 + kj]);
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return s;
    endfunction

    task automatic load(input int mode);
        for (int i = 0; i < 64; i++) begin
            case (mode)
                0: img_mem[i] = 16'sd1;
                1: img_mem[i] = 16'(i);
                2, 3: img_mem[i] = 16'sh7FFF;
                4: img_mem[i] = 16'($urandom);
                default: img_mem[i] = 16'(int'($urandom_range(127, 0)) - 64);
            endcase
        end
        for (int i = 0; i < 16; i++) begin
            case (mode)
                0: ker_mem[i] = 16'sd1;
                1: ker_mem[i] = (i == 4) ? 16'sd1 : 16'sd0;
                2: ker_mem[i] = 16'sh7FFF;
                3: ker_mem[i] = 16'sh8001;
                4: ker_mem[i] = 16'($urandom);
                default: ker_mem[i] = 16'(int'($urandom_range(127, 0)) - 64);
            endcase
        end
    endtask

    // Cycle n is the value seen at rising edge n, where edge 0 samples start.
    task automatic run_conv(input int pulse_at, input int reset_at, input bit hold);
        longint exp_q[$];
        int n_wr = 0;
        int n_done = 0;
        int done_cyc = -1;
        for (int oi = 0; oi < 6; oi++)
            for (int oj = 0; oj < 6; oj++)
                exp_q.push_back(model(oi, oj));
        @(negedge clock);
        start = 1'b1;
        for (int cyc = 1; cyc <= 460; cyc++) begin
            @(negedge clock);
            if (out_we) begin
                if (n_wr < 36) begin
                    check("wr_addr", out_addr, n_wr);
                    check("wr_data", out_data, exp_q[n_wr]);
                    check("wr_cycle", cyc, 11 + 11 * n_wr);
                end
                if (n_wr == 0) begin
                    check("img_addr_idle", img_addr, 0);
                    check("ker_addr_idle", ker_addr, 0);
                end
                n_wr++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (done_cyc > 0 && cyc == done_cyc + 1) begin
                check("idle_after_done", busy, 0);
                if (!hold) break;
            end
            if (hold && done_cyc > 0 && cyc == done_cyc + 2) begin
                check("relaunch_busy", busy, 1);
                break;
            end
            start = hold || (cyc == pulse_at);
            if (reset_at > 0 && cyc == reset_at) begin
                reset = 1'b1;
                #1;
                check("abort_busy", busy, 0);
                check("abort_we", out_we, 0);
                check("abort_done", done, 0);
            end
            if (reset_at > 0 && cyc == reset_at + 2) reset = 1'b0;
        end
        start = 1'b0;
        check("wr_count", n_wr, (reset_at > 0) ? reset_at / 11 : 36);
        check("done_count", n_done, (reset_at > 0) ? 0 : 1);
        if (reset_at == 0) check("done_cycle", done_cyc, 397);
        if (hold) begin
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
        end
    endtask

    task automatic run_small();
        int n_wr = 0;
        int done_cyc = -1;
        longint s = 0;
        for (int i = 0; i < 16; i++) begin
            img3_mem[i] = (i < 9) ? 16'(i + 1) : 16'sd0;
            ker3_mem[i] = (i < 9) ? 16'sd1 : 16'sd0;
        end
        for (int i = 0; i < 9; i++) s += longint'(img3_mem[i]) * longint'(ker3_mem[i]);
        s = s >>> 1;
        @(negedge clock);
        start3 = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clock);
            start3 = 1'b0;
            if (out_we3) begin
                check("s3_addr", out_addr3, 0);
                check("s3_data", out_data3, s);
                check("s3_wr_cycle", cyc, 11);
                n_wr++;
            end
            if (done3) done_cyc = cyc;
        end
        check("s3_wr_count", n_wr, 1);
        check("s3_done_cycle", done_cyc, 12);
        check("s3_idle", busy3, 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) img_mem[i] = '0;
        for (int i = 0; i < 16; i++) begin
            ker_mem[i]  = '0;
            img3_mem[i] = '0;
            ker3_mem[i] = '0;
        end
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_we", out_we, 0);
        check("rst_img_addr", img_addr, 0);
        check("rst_ker_addr", ker_addr, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_data", out_data, 0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_busy", busy, 0);

        load(0); run_conv(0, 0, 1'b0);
        load(1); run_conv(0, 0, 1'b0);
        load(2); run_conv(0, 0, 1'b0);
        load(3); run_conv(0, 0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            load(4); run_conv(0, 0, 1'b0);
            load(5); run_conv(0, 0, 1'b0);
        end
        load(0); run_conv(50, 0, 1'b0);
        load(5); run_conv(0, 120, 1'b0);
        load(5); run_conv(0, 0, 1'b0);
        load(1); run_conv(0, 0, 1'b1);
        run_small();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
